// File: rtl/csa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_pkg : shared state encoding and sizing helpers for csa_resolver |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package csa_pkg;

  localparam int CSA_CHUNK_DEFAULT = 16;

  typedef logic [1:0] csa_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Two guard bits on top of WIDTH hold the full sum + 2*carry value.
  function automatic int csa_nchunk(input int width, input int chunk);
    return (width + 2 + chunk - 1) / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_chunk_adder : combinational CHUNK-bit adder with carry in/out   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module csa_chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csa_resolver : multi-cycle chunked CPA turning sum/carry into binary |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = 62,
  parameter int CHUNK = CSA_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_data,
  output logic             busy
);

  localparam int NCHUNK = csa_nchunk(WIDTH, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] CNT_END = CW'(NCHUNK);

  csa_state_t    state_q, state_d;
  logic [PW-1:0] a_q, a_d;
  logic [PW-1:0] b_q, b_d;
  logic [PW-1:0] res_q, res_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CHUNK-1:0] add_s;
  logic             add_co;

  csa_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i   (a_q[CHUNK-1:0]),
    .b_i   (b_q[CHUNK-1:0]),
    .cin_i (carry_q),
    .s_o   (add_s),
    .cout_o(add_co)
  );

  // Operands shift down one slice per add; result slices enter at the top
  // so slice k lands at bit k*CHUNK once all NCHUNK slices are in. The
  // cycle with cnt_q == NCHUNK only holds, leaving the top carry-out visible.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = {{(PW-WIDTH){1'b0}}, in_sum};
          b_d     = {{(PW-WIDTH-1){1'b0}}, in_carry, 1'b0};
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (cnt_q == CNT_END) begin
          state_d = S_DONE;
        end else begin
          res_d   = {add_s, res_q[PW-1:CHUNK]};
          a_d     = a_q >> CHUNK;
          b_d     = b_q >> CHUNK;
          carry_d = add_co;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_ADD);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = res_q[WIDTH+1:0];

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_csa_resolver : randomized self-checking bench for csa_resolver   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_csa_resolver;

  localparam int WIDTH = 62;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_carry = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH+1:0] out_data;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_resolver #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference value: plain integer arithmetic on the pair's weights.
  function automatic logic [63:0] ref_val(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    return 64'(s) + (64'(c) << 1);
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  // Called just after the accepting edge; returns at the negedge where out_valid is seen.
  task automatic await_result(input logic [63:0] exp, input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
    end while (!out_valid && cyc < 12);
    chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_topcarry"}, 64'(dut.carry_q), 64'd0);
    chk({tag, "_inrdy_done"}, 64'(in_ready), 64'd0);
  endtask

  task automatic xfer(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input int hold, input string tag);
    logic [63:0] exp;
    exp = ref_val(s, c);
    wait_ready(tag);
    in_sum    = s;
    in_carry  = c;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    await_result(exp, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_hold"}, out_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] s, c, s2, c2;
    logic [63:0] e1, e2;
    int vcount;

    #3 rst_n = 1'b0;
    #4;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xfer('0, '0, 0, "zero");
    chk("zero_lit", out_data, 64'd0);
    xfer(62'h0000_0000_0000_FFFF, 62'h1, 0, "xchunk");
    chk("xchunk_lit", out_data, 64'h1_0001);
    xfer({WIDTH{1'b1}}, 62'h1, 0, "ripple");
    chk("ripple_lit", out_data, 64'h4000_0000_0000_0001);
    xfer({WIDTH{1'b1}}, {WIDTH{1'b1}}, 0, "max");

    // Backpressure with a competing pair presented throughout DONE.
    s  = 62'h1234_5678_9ABC_DEF0;
    c  = 62'h0FED_CBA9_8765_4321;
    s2 = 62'h3333_0000_FFFF_1111;
    c2 = 62'h0000_FFFF_0001_FFFF;
    e1 = ref_val(s, c);
    e2 = ref_val(s2, c2);
    wait_ready("bp1");
    in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    await_result(e1, "bp1");
    in_sum = s2; in_carry = c2; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_data", out_data, e1);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    await_result(e2, "bp2");

    // Asynchronous reset two cycles after accept.
    wait_ready("rst");
    in_sum = {WIDTH{1'b1}}; in_carry = 62'h5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("mid_rst_no_valid", 64'(vcount), 64'd0);
    xfer(62'h2AAA_AAAA_AAAA_AAAA, 62'h1555_5555_5555_5555, 0, "post_rst");

    for (int k = 0; k < 40; k++) begin
      s = WIDTH'({$urandom, $urandom});
      c = WIDTH'({$urandom, $urandom});
      case ($urandom_range(0, 5))
        0: s = {WIDTH{1'b1}};
        1: c = {WIDTH{1'b1}};
        2: c = ~s;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(s, c, int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
